// File: rtl/io_device_port.sv
// Device-side byte I/O port: an RX FIFO feeding the processor over a 4-phase
// input handshake, and a TX FIFO capturing processor writes over a 4-phase
// output handshake. Every output comes straight from a register.
module io_device_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic          host_wr_en,
    input  logic [7:0]    host_wr_data,
    output logic          host_wr_full,
    output logic [7:0]    input_bus,
    output logic          in_dev_hs,
    input  logic          in_dev_ack,
    input  logic [7:0]    output_bus,
    input  logic          out_req,
    output logic          out_dev_hs,
    output logic          out_dev_ack,
    input  logic          host_rd_en,
    output logic [7:0]    host_rd_data,
    output logic          host_rd_empty,
    output logic [AW:0]   rx_count,
    output logic [AW:0]   tx_count,
    output logic          err_ovf,
    output logic          err_udf
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IN_IDLE, IN_PRESENT, IN_RELEASE} in_state_e;
    typedef enum logic [1:0] {OUT_READY, OUT_ACK, OUT_FULL}    out_state_e;

    in_state_e   in_state_q, in_state_d;
    out_state_e  out_state_q, out_state_d;

    logic [7:0]  rx_mem_q [DEPTH];
    logic [7:0]  tx_mem_q [DEPTH];
    logic [AW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
    logic [AW:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
    logic [7:0]  in_bus_q, in_bus_d;
    logic        in_hs_q, in_hs_d, out_hs_q, out_hs_d, out_ack_q, out_ack_d;
    logic        wr_full_q, rd_empty_q, ovf_q, ovf_d, udf_q, udf_d, out_req_q;
    logic        rx_push, rx_pop, tx_push, tx_pop, tx_ovf;

    // RX side: host push plus the input handshake FSM that pops the head
    always_comb begin
        rx_push    = host_wr_en && (rx_count_q != FULL_CNT);
        rx_pop     = 1'b0;
        in_state_d = in_state_q;
        in_hs_d    = in_hs_q;
        in_bus_d   = in_bus_q;
        case (in_state_q)
            IN_IDLE: if (rx_count_q != '0) begin
                in_bus_d   = rx_mem_q[rx_rd_q];
                rx_pop     = 1'b1;
                in_hs_d    = 1'b1;
                in_state_d = IN_PRESENT;
            end
            IN_PRESENT: if (in_dev_ack) begin
                in_hs_d    = 1'b0;
                in_state_d = IN_RELEASE;
            end
            IN_RELEASE: if (!in_dev_ack) in_state_d = IN_IDLE;
            default: in_state_d = IN_IDLE;
        endcase
        rx_count_d = rx_count_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end

    // TX side: output handshake FSM captures writes; host pops the head
    always_comb begin
        tx_pop      = host_rd_en && (tx_count_q != '0);
        tx_push     = 1'b0;
        tx_ovf      = 1'b0;
        out_state_d = out_state_q;
        out_ack_d   = out_ack_q;
        case (out_state_q)
            OUT_READY: if (out_req) begin
                if (tx_count_q != FULL_CNT) begin
                    tx_push     = 1'b1;
                    out_ack_d   = 1'b1;
                    out_state_d = OUT_ACK;
                end else begin
                    tx_ovf = 1'b1;
                end
            end
            OUT_ACK: if (!out_req) begin
                out_ack_d   = 1'b0;
                out_state_d = (tx_count_q == FULL_CNT) ? OUT_FULL : OUT_READY;
            end
            OUT_FULL: begin
                // a refused write is flagged once, on its leading edge
                if (out_req && !out_req_q) tx_ovf = 1'b1;
                if (tx_count_q != FULL_CNT) out_state_d = OUT_READY;
            end
            default: out_state_d = OUT_READY;
        endcase
        out_hs_d   = (out_state_d == OUT_READY);
        tx_count_d = tx_count_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        ovf_d      = ovf_q | (host_wr_en && (rx_count_q == FULL_CNT)) | tx_ovf;
        udf_d      = udf_q | (host_rd_en && (tx_count_q == '0));
    end

    // RX storage needs no reset: only slots below the count are ever read
    always_ff @(posedge g_clk) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= host_wr_data;
    end

    // Pointers, counts, FSM state and registered outputs
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_READY;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_count_q  <= '0;
            tx_count_q  <= '0;
            in_bus_q    <= '0;
            in_hs_q     <= 1'b0;
            out_hs_q    <= 1'b0;
            out_ack_q   <= 1'b0;
            wr_full_q   <= 1'b0;
            rd_empty_q  <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            out_req_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tx_mem_q[i] <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            if (tx_push) begin
                tx_mem_q[tx_wr_q] <= output_bus;
                tx_wr_q           <= tx_wr_q + 1'b1;
            end
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            rx_count_q  <= rx_count_d;
            tx_count_q  <= tx_count_d;
            in_bus_q    <= in_bus_d;
            in_hs_q     <= in_hs_d;
            out_hs_q    <= out_hs_d;
            out_ack_q   <= out_ack_d;
            wr_full_q   <= (rx_count_d == FULL_CNT);
            rd_empty_q  <= (tx_count_d == '0);
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            out_req_q   <= out_req;
        end
    end

    assign host_wr_full  = wr_full_q;
    assign input_bus     = in_bus_q;
    assign in_dev_hs     = in_hs_q;
    assign out_dev_hs    = out_hs_q;
    assign out_dev_ack   = out_ack_q;
    assign host_rd_data  = tx_mem_q[tx_rd_q];
    assign host_rd_empty = rd_empty_q;
    assign rx_count      = rx_count_q;
    assign tx_count      = tx_count_q;
    assign err_ovf       = ovf_q;
    assign err_udf       = udf_q;
endmodule

// File: tb/tb_io_device_port.sv
// Directed bench for io_device_port: handshakes, FIFO fill/overflow, reset abort.
module tb_io_device_port;
    logic       g_clk = 1'b0;
    logic       g_clr, host_wr_en, in_dev_ack, out_req, host_rd_en;
    logic [7:0] host_wr_data, output_bus;
    logic       host_wr_full, in_dev_hs, out_dev_hs, out_dev_ack, host_rd_empty, err_ovf, err_udf;
    logic [7:0] input_bus, host_rd_data;
    logic [2:0] rx_count, tx_count;
    int checks = 0;
    int failures = 0;

    io_device_port #(.DEPTH(4), .AW(2)) dut (
        .g_clk(g_clk), .g_clr(g_clr),
        .host_wr_en(host_wr_en), .host_wr_data(host_wr_data), .host_wr_full(host_wr_full),
        .input_bus(input_bus), .in_dev_hs(in_dev_hs), .in_dev_ack(in_dev_ack),
        .output_bus(output_bus), .out_req(out_req), .out_dev_hs(out_dev_hs), .out_dev_ack(out_dev_ack),
        .host_rd_en(host_rd_en), .host_rd_data(host_rd_data), .host_rd_empty(host_rd_empty),
        .rx_count(rx_count), .tx_count(tx_count), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 g_clk = ~g_clk;

    // advance one rising edge, then settle away from it
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        g_clr = 1'b1; host_wr_en = 1'b0; host_wr_data = 8'h00; in_dev_ack = 1'b0;
        output_bus = 8'h00; out_req = 1'b0; host_rd_en = 1'b0;
        step(); step();
        chk("rst_in_hs", in_dev_hs, 0);      chk("rst_in_bus", input_bus, 0);
        chk("rst_out_hs", out_dev_hs, 0);    chk("rst_out_ack", out_dev_ack, 0);
        chk("rst_full", host_wr_full, 0);    chk("rst_empty", host_rd_empty, 1);
        chk("rst_rd_data", host_rd_data, 0); chk("rst_rx_cnt", rx_count, 0);
        chk("rst_tx_cnt", tx_count, 0);      chk("rst_ovf", err_ovf, 0);
        chk("rst_udf", err_udf, 0);
        g_clr = 1'b0;
        step();
        chk("ready_hs", out_dev_hs, 1);

        // single byte: hs two edges after push
        host_wr_en = 1'b1; host_wr_data = 8'hA5;
        step();
        host_wr_en = 1'b0;
        chk("a5_cnt1", rx_count, 1);   chk("a5_hs_early", in_dev_hs, 0);
        step();
        chk("a5_hs", in_dev_hs, 1);    chk("a5_bus", input_bus, 8'hA5);
        chk("a5_cnt0", rx_count, 0);

        // ack held three edges; next byte waits for ack low
        in_dev_ack = 1'b1;
        step();
        chk("ack_hs_drop", in_dev_hs, 0);
        host_wr_en = 1'b1; host_wr_data = 8'h77;
        step();
        host_wr_en = 1'b0;
        step();
        chk("ack_hold_hs", in_dev_hs, 0); chk("ack_hold_cnt", rx_count, 1);
        chk("ack_hold_bus", input_bus, 8'hA5);
        in_dev_ack = 1'b0;
        step();
        chk("rel_idle_hs", in_dev_hs, 0);
        step();
        chk("b77_hs", in_dev_hs, 1); chk("b77_bus", input_bus, 8'h77);
        in_dev_ack = 1'b1; step();
        in_dev_ack = 1'b0; step();

        // five pushes with ack withheld: 01 presented, 02..05 fill the FIFO
        for (int i = 1; i <= 5; i++) begin
            host_wr_en = 1'b1; host_wr_data = 8'(i);
            step();
        end
        chk("fill_cnt", rx_count, 4);  chk("fill_full", host_wr_full, 1);
        chk("fill_bus", input_bus, 8'h01); chk("fill_hs", in_dev_hs, 1);
        chk("fill_ovf", err_ovf, 0);
        host_wr_data = 8'h06;
        step();
        host_wr_en = 1'b0;
        chk("rx_ovf", err_ovf, 1); chk("rx_ovf_cnt", rx_count, 4);
        in_dev_ack = 1'b1; step();
        in_dev_ack = 1'b0; step();
        step();
        chk("next_bus", input_bus, 8'h02); chk("next_hs", in_dev_hs, 1);
        chk("next_cnt", rx_count, 3);

        // reset while in IN_PRESENT
        g_clr = 1'b1;
        step();
        chk("clr_in_hs", in_dev_hs, 0);  chk("clr_in_bus", input_bus, 0);
        chk("clr_rx_cnt", rx_count, 0);  chk("clr_ovf", err_ovf, 0);
        chk("clr_full", host_wr_full, 0);
        g_clr = 1'b0;
        step();
        chk("tx_ready", out_dev_hs, 1);

        // processor writes 3C then C3
        output_bus = 8'h3C; out_req = 1'b1;
        step();
        chk("w1_ack", out_dev_ack, 1); chk("w1_hs", out_dev_hs, 0);
        chk("w1_cnt", tx_count, 1);    chk("w1_empty", host_rd_empty, 0);
        chk("w1_head", host_rd_data, 8'h3C);
        out_req = 1'b0;
        step();
        chk("w1_ack_off", out_dev_ack, 0); chk("w1_hs_back", out_dev_hs, 1);
        output_bus = 8'hC3; out_req = 1'b1;
        step();
        chk("w2_ack", out_dev_ack, 1); chk("w2_cnt", tx_count, 2);
        out_req = 1'b0;
        step();
        host_rd_en = 1'b1;
        step();
        chk("rd1_data", host_rd_data, 8'hC3); chk("rd1_cnt", tx_count, 1);
        step();
        host_rd_en = 1'b0;
        chk("rd2_empty", host_rd_empty, 1); chk("rd2_cnt", tx_count, 0);
        chk("rd2_udf", err_udf, 0);

        // fill TX: hs drops, extra write refused and flagged
        for (int i = 1; i <= 4; i++) begin
            output_bus = 8'(i * 16); out_req = 1'b1;
            step();
            out_req = 1'b0;
            step();
        end
        chk("txf_cnt", tx_count, 4); chk("txf_hs", out_dev_hs, 0);
        out_req = 1'b1;
        step();
        chk("txf_noack", out_dev_ack, 0); chk("txf_ovf", err_ovf, 1);
        chk("txf_cnt2", tx_count, 4);
        out_req = 1'b0; host_rd_en = 1'b1;
        step();
        host_rd_en = 1'b0;
        chk("txf_pop_cnt", tx_count, 3); chk("txf_pop_hs", out_dev_hs, 0);
        chk("txf_head", host_rd_data, 8'h20);
        step();
        chk("txf_hs_back", out_dev_hs, 1);

        // reset while in OUT_ACK
        output_bus = 8'h50; out_req = 1'b1;
        step();
        chk("ack_pre_clr", out_dev_ack, 1); chk("ack_pre_cnt", tx_count, 4);
        g_clr = 1'b1;
        step();
        chk("clr_ack", out_dev_ack, 0);     chk("clr_out_hs", out_dev_hs, 0);
        chk("clr_tx_cnt", tx_count, 0);     chk("clr_empty", host_rd_empty, 1);
        chk("clr_rd_data", host_rd_data, 0); chk("clr_ovf2", err_ovf, 0);
        g_clr = 1'b0; out_req = 1'b0;
        step();

        // pop while empty
        host_rd_en = 1'b1;
        step();
        host_rd_en = 1'b0;
        chk("udf", err_udf, 1); chk("udf_cnt", tx_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
